// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, widths and helpers for spi_bus_arbiter.
// Round-robin arbitration is compiled in when SPI_ARB_RR_EN is defined.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int BIT_CNT_W  = $clog2(SPI_DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // a and b are both below n, so one subtraction is enough
  function automatic int wrap_add(
    input int a,
    input int b,
    input int n
  );
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: client request/grant bus plus the SPI pins.
// master = arbiter side, slave = clients and the SPI slave device.
interface spi_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import spi_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [SPI_DATA_W*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [SPI_DATA_W-1:0]         rdata;
  logic                          busy;
  logic                          sclk;
  logic                          ss;
  logic                          mosi;
  logic                          miso;

  modport master (
    input  req,
    input  wdata,
    input  miso,
    output gnt,
    output done,
    output rdata,
    output busy,
    output sclk,
    output ss,
    output mosi
  );

  modport slave (
    output req,
    output wdata,
    output miso,
    input  gnt,
    input  done,
    input  rdata,
    input  busy,
    input  sclk,
    input  ss,
    input  mosi
  );

endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: clock divider, sclk/ss/mosi generation and shift registers.
// Phase is supplied by the arbiter FSM; start loads a byte, finish ends HOLD.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  state_t                state,
  input  logic                  start,
  input  logic [SPI_DATA_W-1:0] data,
  input  logic                  miso,
  output logic                  tick,
  output logic                  last,
  output logic                  finish,
  output logic [SPI_DATA_W-1:0] rx,
  output logic                  sclk,
  output logic                  ss,
  output logic                  mosi
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_MAX =
    BIT_CNT_W'(SPI_DATA_W - 1);

  logic [CW-1:0]         cnt;
  logic [SPI_DATA_W-1:0] shreg;
  logic [BIT_CNT_W-1:0]  bitcnt;
  logic                  active;
  logic                  shift_tick;

  assign active = (state == SETUP) ||
                  (state == SHIFT) ||
                  (state == HOLD);

  assign tick       = active && (cnt == DIV_MAX);
  assign shift_tick = (state == SHIFT) && tick;
  assign last       = shift_tick && sclk && (bitcnt == BIT_MAX);
  assign finish     = (state == HOLD) && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      rx     <= '0;
      sclk   <= 1'b0;
      ss     <= 1'b1;
      mosi   <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      shreg  <= data;
      bitcnt <= '0;
      rx     <= '0;
      sclk   <= 1'b0;
      ss     <= 1'b0;
      mosi   <= data[SPI_DATA_W-1];
    end else begin
      if (active) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end
      if (shift_tick) begin
        sclk <= ~sclk;
        if (!sclk) begin
          rx <= {rx[SPI_DATA_W-2:0], miso};
        end else begin
          bitcnt <= bitcnt + BIT_CNT_W'(1);
          // the last falling edge leaves bit 0 on mosi through HOLD
          if (!last) begin
            shreg <= {shreg[SPI_DATA_W-2:0], 1'b0};
            mosi  <= shreg[SPI_DATA_W-2];
          end
        end
      end
      if (finish) begin
        ss   <= 1'b1;
        mosi <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI mode-0 master among NUM_REQ clients.
// Fixed priority by default; SPI_ARB_RR_EN selects round-robin.
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  spi_bus_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                state;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    win_oh;
  logic [SPI_DATA_W-1:0] rdata;
  logic [SPI_DATA_W-1:0] rx;
  logic [SPI_DATA_W-1:0] tx;
  logic [IW-1:0]         win_idx;
  logic                  busy;
  logic                  hit;
  logic                  start;
  logic                  tick;
  logic                  last;
  logic                  finish;
  logic                  sclk;
  logic                  ss;
  logic                  mosi;

`ifdef SPI_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;

  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'(wrap_add(int'(rr_ptr), k, NUM_REQ));
      if (!hit && bus.req[idx]) begin
        hit     = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (start) begin
      rr_ptr <= IW'(wrap_add(int'(win_idx), 1, NUM_REQ));
    end
  end
`else
  always_comb begin
    hit     = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && bus.req[k]) begin
        hit     = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    win_oh = '0;
    tx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_oh[k] = hit;
        tx = bus.wdata[SPI_DATA_W*k +: SPI_DATA_W];
      end
    end
  end

  assign start = (state == IDLE) && hit;

  // wdata is captured only at grant; later changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      busy  <= 1'b0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            gnt   <= win_oh;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (last) state <= HOLD;
        end
        HOLD: begin
          if (finish) begin
            done  <= gnt;
            rdata <= rx;
            state <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .start (start),
    .data  (tx),
    .miso  (bus.miso),
    .tick  (tick),
    .last  (last),
    .finish(finish),
    .rx    (rx),
    .sclk  (sclk),
    .ss    (ss),
    .mosi  (mosi)
  );

  assign bus.gnt   = gnt;
  assign bus.done  = done;
  assign bus.rdata = rdata;
  assign bus.busy  = busy;
  assign bus.sclk  = sclk;
  assign bus.ss    = ss;
  assign bus.mosi  = mosi;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed vectors plus corner sequences for spi_bus_arbiter.
// Builds for either arbitration policy (SPI_ARB_RR_EN).
module tb_spi_bus_arbiter;

  localparam int NR  = 4;
  localparam int CD  = 4;
  localparam int LAT = 1 + CD * 18 + 1;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [7:0]  sbyte;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic [7:0]  mosi;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

  spi_bus_arbiter #(
    .NUM_REQ(NR),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // mode-0 slave: first bit ready at ss fall, next bit on each sclk fall
  logic [7:0] sbyte = 8'h00;
  logic [3:0] scnt  = 4'd0;
  logic [7:0] mcap  = 8'h00;

  always @(negedge bus.sclk or posedge bus.ss) begin
    if (bus.ss) scnt <= 4'd0;
    else        scnt <= scnt + 4'd1;
  end

  assign bus.miso = scnt[3] ? 1'b0 : sbyte[3'd7 - scnt[2:0]];

  always @(posedge bus.sclk) begin
    if (!bus.ss) mcap <= {mcap[6:0], bus.mosi};
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done == '0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, " done seen"}, 32'(bus.done != '0), 32'd1);
  endtask

  task automatic wait_gnt(input string tag, output int k);
    k = 0;
    while (bus.gnt == '0 && k < 20) begin
      step();
      k++;
    end
    chk({tag, " gnt seen"}, 32'(bus.gnt != '0), 32'd1);
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    bus.wdata = v.wdata;
    sbyte     = v.sbyte;
    bus.req   = v.req;
    n = 1;
    step();
    n++;
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(v.gnt));
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    while (bus.done == '0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT));
    chk({tag, " done"}, 32'(bus.done), 32'(v.gnt));
    chk({tag, " rdata"}, 32'(bus.rdata), 32'(v.rdata));
    chk({tag, " mosi"}, 32'(mcap), 32'(v.mosi));
    bus.req = '0;
    step();
    chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
    chk({tag, " idle"}, 32'({bus.busy, bus.gnt}), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t       tbl [5];
  logic [3:0] cexp [5];
  logic [3:0] dval;
  int         k;
  int         dn;
  int         dones;
  int         regr;
  logic       seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0001, 32'h0000_00EA, 8'hEE, 4'b0001, 8'hEE, 8'hEA};
    tbl[1] = '{4'b0010, 32'h0000_0000, 8'hFF, 4'b0010, 8'hFF, 8'h00};
    tbl[2] = '{4'b0010, 32'h0000_FF00, 8'h00, 4'b0010, 8'h00, 8'hFF};
    tbl[3] = '{4'b1000, 32'h5A00_0000, 8'hA5, 4'b1000, 8'hA5, 8'h5A};
    tbl[4] = '{4'b0110, 32'h0096_C300, 8'h3C, 4'b0010, 8'h3C, 8'hC3};
`ifdef SPI_ARB_RR_EN
    cexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    cexp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset ss", 32'(bus.ss), 32'd1);
    chk("reset sclk", 32'(bus.sclk), 32'd0);
    chk("reset gnt", 32'(bus.gnt), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset rdata", 32'(bus.rdata), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset mosi", 32'(bus.mosi), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_xfer(tbl[i], $sformatf("vec%0d", i));
    end

    // all requesters held high
    pulse_reset();
    @(negedge clk);
    bus.wdata = 32'h4433_2211;
    sbyte     = 8'h81;
    bus.req   = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        step();
        wait_gnt("cont", k);
        chk("cont gap", 32'(k + 1), 32'd2);
      end
      chk($sformatf("cont gnt%0d", i), 32'(bus.gnt), 32'(cexp[i]));
      wait_done("cont");
      chk($sformatf("cont done%0d", i), 32'(bus.done), 32'(cexp[i]));
      chk("cont rdata", 32'(bus.rdata), 32'h81);
    end
    bus.req = '0;
    step();
    step();

    // req[2] dropped mid-SHIFT
    @(negedge clk);
    bus.wdata = 32'h00A5_0000;
    sbyte     = 8'h3C;
    bus.req   = 4'b0100;
    step();
    chk("drop gnt", 32'(bus.gnt), 32'b0100);
    repeat (30) step();
    bus.req = '0;
    dones = 0;
    regr  = 0;
    seen  = 1'b0;
    dval  = '0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (bus.done != '0) begin
        dones++;
        dval = bus.done;
        seen = 1'b1;
      end else if (seen && bus.gnt != '0) begin
        regr++;
      end
    end
    chk("drop done count", 32'(dones), 32'd1);
    chk("drop done who", 32'(dval), 32'b0100);
    chk("drop rdata", 32'(bus.rdata), 32'h3C);
    chk("drop mosi", 32'(mcap), 32'hA5);
    chk("drop regrant", 32'(regr), 32'd0);

    // reset during SHIFT bit 4
    @(negedge clk);
    bus.wdata = 32'h0000_00C7;
    sbyte     = 8'h11;
    bus.req   = 4'b0001;
    step();
    chk("rstmid gnt", 32'(bus.gnt), 32'b0001);
    repeat (38) step();
    chk("rstmid active", 32'(bus.ss), 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    step();
    chk("rstmid ss", 32'(bus.ss), 32'd1);
    chk("rstmid sclk", 32'(bus.sclk), 32'd0);
    chk("rstmid gnt0", 32'(bus.gnt), 32'd0);
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    chk("rstmid done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (10) begin
      step();
      if (bus.done != '0) dn++;
    end
    chk("rstmid no done", 32'(dn), 32'd0);
    do_xfer('{4'b0100, 32'h0096_0000, 8'h69, 4'b0100, 8'h69, 8'h96},
            "after rst");

    // back-to-back on one requester: 00/FF then FF/00
    @(negedge clk);
    bus.wdata = 32'h0000_0000;
    sbyte     = 8'hFF;
    bus.req   = 4'b0010;
    wait_done("b2b first");
    chk("b2b rdata1", 32'(bus.rdata), 32'hFF);
    chk("b2b mosi1", 32'(mcap), 32'h00);
    bus.wdata = 32'h0000_FF00;
    sbyte     = 8'h00;
    step();
    wait_gnt("b2b", k);
    chk("b2b gap", 32'(k + 1), 32'd2);
    chk("b2b gnt", 32'(bus.gnt), 32'b0010);
    @(negedge clk);
    bus.wdata = 32'h0000_0000;
    wait_done("b2b second");
    chk("b2b rdata2", 32'(bus.rdata), 32'h00);
    chk("b2b mosi2", 32'(mcap), 32'hFF);
    bus.req = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
